// File: rtl/vliw_fwd_hazard.sv
// Forwarding-select and load-use interlock unit for an N-lane VLIW pipeline (ID/EX boundary).
// Optional N-flag forwarding is compiled in when VLIW_FWD_NFLAG_EN is defined.
module vliw_fwd_hazard #(
  parameter int LANES  = 2,
  parameter int SRCS   = 2,
  parameter int REG_AW = 3,
  parameter int SEL_W  = $clog2(2*LANES+1),
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_hold,
  input  logic                          id_valid,
  input  logic [LANES*SRCS*REG_AW-1:0]  id_src_addr,
  input  logic [LANES*SRCS-1:0]         id_src_use,
  input  logic [LANES*REG_AW-1:0]       id_dst_addr,
  input  logic [LANES-1:0]              id_wr,
  input  logic [LANES-1:0]              id_is_load,
  input  logic [LANES-1:0]              id_flag_wr,
  input  logic                          id_flag_rd,
  output logic                          stall,
  output logic [LANES*SRCS*SEL_W-1:0]   ex_fwd_sel,
  output logic [SEL_W-1:0]              ex_nflag_sel,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int OPS = LANES * SRCS;

  // S1 = descriptor of the bundle now in EX, S2 = the one now in MEM.
  logic [LANES-1:0][REG_AW-1:0] s1_dst, s2_dst;
  logic [LANES-1:0]             s1_wr, s2_wr;
  logic [LANES-1:0]             s1_load;

  logic [OPS*SEL_W-1:0] fwd_sel_d;
  logic                 load_hit;

  // Lanes of a stage whose destination equals addr.
  function automatic logic [LANES-1:0] dst_match(
    input logic [REG_AW-1:0]             addr,
    input logic [LANES-1:0]              wr,
    input logic [LANES-1:0][REG_AW-1:0]  dst
  );
    logic [LANES-1:0] hit;
    for (int k = 0; k < LANES; k++)
      hit[k] = wr[k] && (dst[k] == addr);
    return hit;
  endfunction

  // EX/MEM beats MEM/WB; within a stage the highest lane wins (later writes override).
  function automatic logic [SEL_W-1:0] pick_sel(
    input logic [LANES-1:0] s1_hit,
    input logic [LANES-1:0] s2_hit
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = 0; k < LANES; k++)
      if (s2_hit[k]) sel = SEL_W'(LANES + k + 1);
    for (int k = 0; k < LANES; k++)
      if (s1_hit[k]) sel = SEL_W'(k + 1);
    return sel;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_sel_d = '0;
    load_hit  = 1'b0;
    for (int op = 0; op < OPS; op++) begin
      if (id_valid && id_src_use[op]) begin
        fwd_sel_d[op*SEL_W +: SEL_W] =
          pick_sel(dst_match(id_src_addr[op*REG_AW +: REG_AW], s1_wr, s1_dst),
                   dst_match(id_src_addr[op*REG_AW +: REG_AW], s2_wr, s2_dst));
        if (|dst_match(id_src_addr[op*REG_AW +: REG_AW], s1_wr & s1_load, s1_dst))
          load_hit = 1'b1;
      end
    end
  end

  // Loads in S2 forward from MEM/WB, so only an S1 load can force a bubble.
  assign stall = id_valid && load_hit;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over hold and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_dst     <= '0;
      s1_wr      <= '0;
      s1_load    <= '0;
      s2_dst     <= '0;
      s2_wr      <= '0;
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
    end else if (!pipe_hold) begin
      s2_dst <= s1_dst;
      s2_wr  <= s1_wr;
      if (stall) begin
        s1_dst     <= '0;
        s1_wr      <= '0;
        s1_load    <= '0;
        ex_fwd_sel <= '0;
        if (stall_cnt != {CNT_W{1'b1}})
          stall_cnt <= stall_cnt + 1'b1;
      end else begin
        s1_dst     <= id_valid ? id_dst_addr : '0;
        s1_wr      <= id_valid ? id_wr       : '0;
        s1_load    <= id_valid ? id_is_load  : '0;
        ex_fwd_sel <= fwd_sel_d;
      end
    end
  end

`ifdef VLIW_FWD_NFLAG_EN
  logic [LANES-1:0] s1_flag, s2_flag;
  logic [SEL_W-1:0] nflag_sel_d;

  always_comb begin
    nflag_sel_d = '0;
    if (id_valid && id_flag_rd)
      nflag_sel_d = pick_sel(s1_flag, s2_flag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_flag      <= '0;
      s2_flag      <= '0;
      ex_nflag_sel <= '0;
    end else if (!pipe_hold) begin
      s2_flag <= s1_flag;
      if (stall) begin
        s1_flag      <= '0;
        ex_nflag_sel <= '0;
      end else begin
        s1_flag      <= id_valid ? id_flag_wr : '0;
        ex_nflag_sel <= nflag_sel_d;
      end
    end
  end
`else
  // Flag forwarding compiled out: the flag inputs are intentionally unused.
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{id_flag_wr, id_flag_rd};
  assign ex_nflag_sel       = '0;
`endif

endmodule

// File: tb/tb_vliw_fwd_hazard.sv
// Directed bench for vliw_fwd_hazard: forwarding selects, load-use stall, hold, flag, saturation, reset.
// A second instance with CNT_W=4 exercises counter saturation on the same stimulus.
module tb_vliw_fwd_hazard;

  localparam int LANES  = 2;
  localparam int SRCS   = 2;
  localparam int REG_AW = 3;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;

`ifdef VLIW_FWD_NFLAG_EN
  localparam logic [31:0] FLAG_EX_EXP = 32'd1;
`else
  localparam logic [31:0] FLAG_EX_EXP = 32'd0;
`endif

  logic                         clk;
  logic                         reset;
  logic                         pipe_hold;
  logic                         id_valid;
  logic [LANES*SRCS*REG_AW-1:0] id_src_addr;
  logic [LANES*SRCS-1:0]        id_src_use;
  logic [LANES*REG_AW-1:0]      id_dst_addr;
  logic [LANES-1:0]             id_wr;
  logic [LANES-1:0]             id_is_load;
  logic [LANES-1:0]             id_flag_wr;
  logic                         id_flag_rd;

  logic                         stall, stall_s;
  logic [LANES*SRCS*SEL_W-1:0]  ex_fwd_sel, ex_fwd_sel_s;
  logic [SEL_W-1:0]             ex_nflag_sel, ex_nflag_sel_s;
  logic [CNT_W-1:0]             stall_cnt;
  logic [3:0]                   stall_cnt_s;

  int total = 0;
  int bad   = 0;

  vliw_fwd_hazard #(.LANES(LANES), .SRCS(SRCS), .REG_AW(REG_AW), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_use(id_src_use), .id_dst_addr(id_dst_addr),
    .id_wr(id_wr), .id_is_load(id_is_load), .id_flag_wr(id_flag_wr), .id_flag_rd(id_flag_rd),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel), .ex_nflag_sel(ex_nflag_sel), .stall_cnt(stall_cnt)
  );

  vliw_fwd_hazard #(.LANES(LANES), .SRCS(SRCS), .REG_AW(REG_AW), .SEL_W(SEL_W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_use(id_src_use), .id_dst_addr(id_dst_addr),
    .id_wr(id_wr), .id_is_load(id_is_load), .id_flag_wr(id_flag_wr), .id_flag_rd(id_flag_rd),
    .stall(stall_s), .ex_fwd_sel(ex_fwd_sel_s), .ex_nflag_sel(ex_nflag_sel_s), .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_use  = '0;
    id_dst_addr = '0;
    id_wr       = '0;
    id_is_load  = '0;
    id_flag_wr  = '0;
    id_flag_rd  = 1'b0;
  endtask

  task automatic flush();
    clr();
    tick();
    tick();
  endtask

  task automatic wr_lane(input int l, input logic [REG_AW-1:0] dst, input logic ld);
    id_valid                      = 1'b1;
    id_wr[l]                      = 1'b1;
    id_is_load[l]                 = ld;
    id_dst_addr[l*REG_AW +: REG_AW] = dst;
  endtask

  task automatic rd_src(input int l, input int s, input logic [REG_AW-1:0] addr);
    id_valid                                = 1'b1;
    id_src_use[l*SRCS+s]                    = 1'b1;
    id_src_addr[(l*SRCS+s)*REG_AW +: REG_AW] = addr;
  endtask

  function automatic logic [SEL_W-1:0] fsel(input int l, input int s);
    return ex_fwd_sel[(l*SRCS+s)*SEL_W +: SEL_W];
  endfunction

  initial begin
    clr();
    pipe_hold = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_stall", stall, 0);
    check("rst_fwd", ex_fwd_sel, 0);
    check("rst_nflag", ex_nflag_sel, 0);
    check("rst_cnt", stall_cnt, 0);

    // ALU chain, back to back: EX/MEM lane0
    clr(); wr_lane(0, 3'd3, 1'b0); tick();
    clr(); rd_src(1, 0, 3'd3); rd_src(0, 1, 3'd4); #1;
    check("alu_stall", stall, 0);
    tick();
    check("alu_exmem", fsel(1, 0), 1);
    check("alu_nomatch", fsel(0, 1), 0);
    flush();

    // ALU chain with one bubble: MEM/WB lane0
    clr(); wr_lane(0, 3'd3, 1'b0); tick();
    clr(); tick();
    rd_src(1, 0, 3'd3); tick();
    check("alu_memwb", fsel(1, 0), 3);
    flush();

    // Lanes of one bundle read pre-bundle values
    clr(); wr_lane(0, 3'd6, 1'b0); rd_src(1, 1, 3'd6); tick();
    check("intra_bundle", fsel(1, 1), 0);
    flush();

    // Highest lane wins within a stage
    clr(); wr_lane(0, 3'd5, 1'b0); wr_lane(1, 3'd5, 1'b0); tick();
    clr(); rd_src(0, 0, 3'd5); tick();
    check("prio_lane", fsel(0, 0), 2);
    flush();

    // EX/MEM lane0 beats MEM/WB lane1
    clr(); wr_lane(1, 3'd5, 1'b0); tick();
    clr(); wr_lane(0, 3'd5, 1'b0); tick();
    clr(); rd_src(0, 1, 3'd5); tick();
    check("prio_stage", fsel(0, 1), 1);
    flush();

    // Load-use: one stall, then MEM/WB lane1
    clr(); wr_lane(1, 3'd2, 1'b1); tick();
    clr(); rd_src(0, 0, 3'd2); id_valid = 1'b0; #1;
    check("novalid_stall", stall, 0);
    id_valid = 1'b1; #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_cnt", stall_cnt, 1);
    check("lu_stall_clr", stall, 0);
    check("lu_bubble_sel", fsel(0, 0), 0);
    tick();
    check("lu_memwb", fsel(0, 0), 4);
    check("lu_cnt_hold", stall_cnt, 1);
    flush();

    // Freeze during a load-use stall
    clr(); wr_lane(1, 3'd2, 1'b1); tick();
    clr(); rd_src(1, 0, 3'd2); pipe_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall", stall, 1);
      check("hold_cnt", stall_cnt, 1);
    end
    pipe_hold = 1'b0; #1;
    check("rel_stall", stall, 1);
    tick();
    check("rel_cnt", stall_cnt, 2);
    check("rel_stall_clr", stall, 0);
    tick();
    check("rel_memwb", fsel(1, 0), 4);
    flush();

    // N-flag forwarding
    clr(); id_valid = 1'b1; id_flag_wr[0] = 1'b1; tick();
    clr(); id_valid = 1'b1; id_flag_rd = 1'b1; tick();
    check("flag_exmem", ex_nflag_sel, FLAG_EX_EXP);
    clr(); id_flag_rd = 1'b1; tick();
    check("flag_novalid", ex_nflag_sel, 0);
    flush();

    // Alternating stalls: a load r2 bundle that also reads r2, 40 cycles -> 20 stalls
    clr(); wr_lane(1, 3'd2, 1'b1); rd_src(0, 0, 3'd2);
    for (int i = 0; i < 40; i++) tick();
    check("sat_cnt", stall_cnt_s, 15);
    check("wide_cnt", stall_cnt, 22);

    // Reset while stalling with a live select
    tick();
    check("pre_rst_stall", stall, 1);
    check("pre_rst_sel", fsel(0, 0), 4);
    reset = 1'b1;
    tick();
    check("mid_rst_stall", stall, 0);
    check("mid_rst_fwd", ex_fwd_sel, 0);
    check("mid_rst_nflag", ex_nflag_sel, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_cnt_sat", stall_cnt_s, 0);
    reset = 1'b0;
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vliw_fwd_hazard.md
# vliw_fwd_hazard

Parametrised forwarding and load-use interlock unit for the N-lane VLIW pipeline. It sits at the ID/EX boundary and keeps its own shadow copies of the EX and MEM stage destination descriptors. From these it produces registered per-operand bypass selects that reach EX together with the bundle, plus a one-cycle stall when a source depends on a load still in EX. It also forwards the N flag and exposes a saturating stall-cycle counter.

## Interface
- LANES, 2: issue slots per bundle (1..4).
- SRCS, 2: source operands per lane.
- REG_AW, 3: register address width.
- SEL_W, $clog2(2*LANES+1): bypass select width.
- CNT_W, 16: stall counter width.

Ports (one clock domain; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- pipe_hold  in  1  global freeze (memory wait); all state holds.
- id_valid  in  1  ID bundle valid.
- id_src_addr  in  LANES*SRCS*REG_AW  source addresses, lane-major, source-minor.
- id_src_use  in  LANES*SRCS  source actually read.
- id_dst_addr  in  LANES*REG_AW  destination per lane.
- id_wr  in  LANES  lane writes a register.
- id_is_load  in  LANES  lane is a load (data ready at end of MEM).
- id_flag_wr  in  LANES  lane writes the N flag.
- id_flag_rd  in  1  bundle consumes the N flag.
- stall  out  1  combinational: hold IF/ID, inject a bubble into ID/EX.
- ex_fwd_sel  out  LANES*SRCS*SEL_W  registered bypass select per operand.
- ex_nflag_sel  out  SEL_W  registered N-flag source select (same encoding).
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Select encoding: 0 = register file/architectural flag; k in 1..LANES = EX/MEM lane k-1; LANES+k = MEM/WB lane k-1.
- Shadows: S1 is the ID/EX descriptor (dst, wr, load, flag_wr per lane). S2 is the EX/MEM descriptor.
- Select computation happens in ID, targeting EX next cycle:
  - match against S1 → EX/MEM code;
  - else match against S2 → MEM/WB code;
  - else 0.
  - A match requires src_use=1, wr=1 and equal address.
  - EX/MEM beats MEM/WB. Within a stage, the highest lane index wins.
- No intra-bundle forwarding: lanes of one bundle read pre-bundle values.
- Load-use hazard: id_valid=1 and any used source matches an S1 lane with wr=1 and load=1 → stall=1. A load in S2 forwards normally from MEM/WB.
- The N-flag select follows the same rule using flag_wr. It is computed only when id_flag_rd=1 and is 0 otherwise.
- Update when pipe_hold=0:
  - stall=1: S2 ← S1; S1 ← bubble (all zeros); selects ← 0; stall_cnt increments, saturating at all-ones.
  - stall=0: S2 ← S1; S1 ← ID fields gated by id_valid; selects ← computed values.
- pipe_hold=1: S1, S2, selects and stall_cnt hold; stall is still driven.

## Timing
- Reset values: S1 and S2 zero, ex_fwd_sel 0, ex_nflag_sel 0, stall_cnt 0. Stall is therefore 0 in the first cycle after reset.
- Select latency is 1 cycle: the values are valid in the cycle the bundle occupies EX.
- Stall is asserted for exactly 1 non-hold cycle per load-use hazard. In the next cycle the load is in S2 and stall deasserts.
- A consumer that depends on two loads in the same S1 bundle still stalls only 1 cycle.
- Reset mid-stall: reset wins, and the shadows and selects are cleared in the same edge.
- pipe_hold and stall together: no state changes and stall_cnt does not increment.
- With id_valid=0, all selects are 0 and stall is 0.

## Configuration
- VLIW_FWD_NFLAG_EN defined: N-flag forwarding is present as described.
- Undefined: ex_nflag_sel is tied to 0, flag_wr is not tracked in the shadows, and id_flag_wr/id_flag_rd are ignored.

## Test plan
- ALU chain: lane0 writes r3; the next bundle lane1 reads r3 → stall=0, that operand's select=1 (EX/MEM lane0) in EX. With one bubble bundle between them, select=LANES+1=3.
- Priority: lanes 0 and 1 both write r5; the consumer reads r5 → select=2 (lane1). If S1 lane0 and S2 lane1 both hit, the select is 1 (EX/MEM wins).
- Load-use: lane1 loads r2; the next bundle reads r2 → stall=1 for one cycle, stall_cnt=1. The following cycle gives stall=0 and select=4 (MEM/WB lane1).
- Freeze: raise pipe_hold during a load-use stall for 3 cycles → stall stays 1, stall_cnt unchanged. After release, 1 stall cycle is counted.
- Flag: lane0 writes N, the next bundle sets id_flag_rd=1 → ex_nflag_sel=1. With the macro undefined → 0.
- Saturation/reset: with CNT_W=4 and 20 forced stalls, stall_cnt=15. Reset during a stall → all outputs 0 at the next edge.
